// File: rtl/prio_req_ctrl_if.sv
// rtl/prio_req_ctrl_if.sv - Handshake bundle between prio_req_ctrl and its environment
//
// Groups the event inputs, the priority-circuit request/grant loop, the
// service handshake and the sticky error flags.
//   master : the controller side (drives req, svc_*, flags)
//   slave  : the environment side (drives ev, grant, idle, svc_ack, flag_clr)
interface prio_req_ctrl_if;
    logic [7:0] ev;
    logic [7:0] req;
    logic [7:0] grant;
    logic       idle;
    logic       svc_valid;
    logic [2:0] svc_id;
    logic       svc_ack;
    logic       svc_done;
    logic [7:0] overrun;
    logic       to_err;
    logic       proto_err;
    logic       flag_clr;

    modport master (
        input  ev, grant, idle, svc_ack, flag_clr,
        output req, svc_valid, svc_id, svc_done, overrun, to_err, proto_err
    );

    modport slave (
        output ev, grant, idle, svc_ack, flag_clr,
        input  req, svc_valid, svc_id, svc_done, overrun, to_err, proto_err
    );
endinterface

// File: rtl/prio_req_ctrl.sv
// rtl/prio_req_ctrl.sv - Request capture and service sequencer for an 8-input priority circuit
//
// Captures event pulses into pending request bits, hands them to an external
// combinational priority circuit, and runs one service handshake per one-hot
// grant. Requests clear on ack or timeout; overrun/timeout/protocol errors are
// sticky until flag_clr.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : master modport of prio_req_ctrl_if
//              in  ev, grant, idle, svc_ack, flag_clr
//              out req, svc_valid, svc_id, svc_done, overrun, to_err, proto_err
module prio_req_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    prio_req_ctrl_if.master   bus
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [2:0]      svc_id_q, svc_id_d;
    logic            svc_done_q, svc_done_d;
    logic [7:0]      req_q, req_d;
    logic [7:0]      overrun_q, overrun_d;
    logic            to_err_q, to_err_d;
    logic            proto_err_q, proto_err_d;

    logic [7:0]      clr;
    logic [2:0]      grant_idx;
    logic            to_set;
    logic            proto_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            svc_id_q    <= '0;
            svc_done_q  <= 1'b0;
            req_q       <= '0;
            overrun_q   <= '0;
            to_err_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            svc_id_q    <= svc_id_d;
            svc_done_q  <= svc_done_d;
            req_q       <= req_d;
            overrun_q   <= overrun_d;
            to_err_q    <= to_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        grant_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (bus.grant[k]) grant_idx = 3'(k);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        svc_id_d   = svc_id_q;
        svc_done_d = 1'b0;
        clr        = '0;
        to_set     = 1'b0;
        proto_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!bus.idle) begin
                    if ($onehot(bus.grant)) begin
                        svc_id_d = grant_idx;
                        cnt_d    = '0;
                        state_d  = ST_SERVICE;
                    end else begin
                        proto_set = 1'b1;
                    end
                end
            end
            ST_SERVICE: begin
                // Ack is checked first so an ack on the last timeout cycle
                // still completes normally.
                if (bus.svc_ack) begin
                    clr        = 8'b1 << svc_id_q;
                    svc_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    clr     = 8'b1 << svc_id_q;
                    to_set  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An event on the clearing edge re-arms the request and is not an overrun.
        req_d       = (req_q & ~clr) | bus.ev;
        overrun_d   = (bus.flag_clr ? 8'h00 : overrun_q) | (bus.ev & req_q & ~clr);
        to_err_d    = (bus.flag_clr ? 1'b0 : to_err_q) | to_set;
        proto_err_d = (bus.flag_clr ? 1'b0 : proto_err_q) | proto_set;
    end

    assign bus.req       = req_q;
    assign bus.svc_valid = (state_q == ST_SERVICE);
    assign bus.svc_id    = svc_id_q;
    assign bus.svc_done  = svc_done_q;
    assign bus.overrun   = overrun_q;
    assign bus.to_err    = to_err_q;
    assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_prio_req_ctrl.sv
// tb/tb_prio_req_ctrl.sv - Scoreboard bench for prio_req_ctrl with a behavioural priority circuit
module tb_prio_req_ctrl;

    logic clk;
    logic rst_n;

    prio_req_ctrl_if bus ();

    prio_req_ctrl #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Priority circuit model: bit 7 highest; optional override for protocol tests.
    logic       ovr_en;
    logic [7:0] ovr_grant;
    logic       ovr_idle;

    always_comb begin
        bus.grant = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (bus.req[k]) bus.grant = 8'b1 << k;
        end
        bus.idle = (bus.req == 8'h00);
        if (ovr_en) begin
            bus.grant = ovr_grant;
            bus.idle  = ovr_idle;
        end
    end

    // Scoreboard queues: expected svc_id at each service start / each svc_done.
    logic [2:0] svc_q[$];
    logic [2:0] done_q[$];
    logic       prev_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else n_pass++;
    endtask

    initial prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.svc_valid && !prev_valid) begin
                if (svc_q.size() == 0) begin
                    n_total++;
                    $display("FAIL svc_start unexpected id=%0d", bus.svc_id);
                end else begin
                    chk("svc_start_id", 32'(bus.svc_id), 32'(svc_q.pop_front()));
                end
            end
            if (bus.svc_done) begin
                if (done_q.size() == 0) begin
                    n_total++;
                    $display("FAIL svc_done unexpected id=%0d", bus.svc_id);
                end else begin
                    chk("svc_done_id", 32'(bus.svc_id), 32'(done_q.pop_front()));
                end
            end
        end
        prev_valid = bus.svc_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ev(input logic [7:0] v);
        bus.ev = v;
        tick();
        bus.ev = 8'h00;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.svc_valid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.svc_valid) begin
            n_total++;
            $display("FAIL %s timeout waiting svc_valid actual=0 required=1", name);
        end
    endtask

    task automatic ack_now();
        bus.svc_ack = 1'b1;
        tick();
        bus.svc_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n        = 1'b0;
        bus.ev       = 8'h00;
        bus.svc_ack  = 1'b0;
        bus.flag_clr = 1'b0;
        ovr_en       = 1'b0;
        ovr_grant    = 8'h00;
        ovr_idle     = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_req",       32'(bus.req),       32'h0);
        chk("rst_svc_valid", 32'(bus.svc_valid), 32'h0);
        chk("rst_svc_id",    32'(bus.svc_id),    32'h0);
        chk("rst_svc_done",  32'(bus.svc_done),  32'h0);
        chk("rst_flags",     {22'b0, bus.overrun, bus.to_err, bus.proto_err}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("quiet_req_valid", {23'b0, bus.req, bus.svc_valid}, 32'h0);
        end

        // Single request on source 4, ack after 3 service cycles
        svc_q.push_back(3'd4);
        pulse_ev(8'h10);
        chk("single_req_captured", 32'(bus.req), 32'h10);
        chk("single_not_yet_valid", 32'(bus.svc_valid), 32'h0);
        tick();
        chk("single_valid_latency", 32'(bus.svc_valid), 32'h1);
        tick();
        tick();
        done_q.push_back(3'd4);
        ack_now();
        chk("single_done_pulse", {30'b0, bus.svc_valid, bus.svc_done}, 32'h1);
        chk("single_req_cleared", 32'(bus.req), 32'h0);
        tick();
        chk("single_done_one_cycle", 32'(bus.svc_done), 32'h0);

        // Priority ordering: 7 before 0, immediate acks
        svc_q.push_back(3'd7);
        svc_q.push_back(3'd0);
        done_q.push_back(3'd7);
        done_q.push_back(3'd0);
        pulse_ev(8'h81);
        wait_valid("prio_first");
        ack_now();
        chk("prio_gap_low", 32'(bus.svc_valid), 32'h0);
        chk("prio_req_mid", 32'(bus.req), 32'h01);
        wait_valid("prio_second");
        ack_now();
        chk("prio_req_end", 32'(bus.req), 32'h0);

        // Overrun, flag clear, and ev on the ack edge
        svc_q.push_back(3'd2);
        pulse_ev(8'h04);
        pulse_ev(8'h04);
        chk("overrun_set", 32'(bus.overrun), 32'h04);
        wait_valid("ovr_svc");
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        chk("overrun_cleared", 32'(bus.overrun), 32'h00);
        done_q.push_back(3'd2);
        svc_q.push_back(3'd2);
        bus.ev      = 8'h04;
        bus.svc_ack = 1'b1;
        tick();
        bus.ev      = 8'h00;
        bus.svc_ack = 1'b0;
        chk("race_req_kept", 32'(bus.req), 32'h04);
        chk("race_no_overrun", 32'(bus.overrun), 32'h00);
        done_q.push_back(3'd2);
        wait_valid("race_resvc");
        ack_now();
        chk("race_req_end", 32'(bus.req), 32'h0);

        // Timeout on source 1
        svc_q.push_back(3'd1);
        pulse_ev(8'h02);
        wait_valid("to_svc");
        chk("to_err_before", 32'(bus.to_err), 32'h0);
        n = 0;
        while (bus.svc_valid && n < 40) begin
            n++;
            tick();
        end
        chk("to_valid_cycles", 32'(n), 32'd16);
        chk("to_err_set", 32'(bus.to_err), 32'h1);
        chk("to_no_done", 32'(bus.svc_done), 32'h0);
        chk("to_req_cleared", 32'(bus.req), 32'h0);
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        chk("to_err_cleared", 32'(bus.to_err), 32'h0);

        // Ack on the final timeout cycle completes normally
        svc_q.push_back(3'd1);
        done_q.push_back(3'd1);
        pulse_ev(8'h02);
        wait_valid("to_last_svc");
        for (int i = 0; i < 15; i++) tick();
        chk("to_last_still_valid", 32'(bus.svc_valid), 32'h1);
        ack_now();
        chk("to_last_done", {30'b0, bus.svc_done, bus.to_err}, 32'h2);
        tick();

        // Protocol error: non-one-hot grant with idle=0
        ovr_en    = 1'b1;
        ovr_grant = 8'h03;
        ovr_idle  = 1'b0;
        tick();
        chk("proto_set", 32'(bus.proto_err), 32'h1);
        chk("proto_no_capture", 32'(bus.svc_valid), 32'h0);
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        chk("proto_set_wins_clr", 32'(bus.proto_err), 32'h1);
        ovr_en = 1'b0;
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        chk("proto_cleared", 32'(bus.proto_err), 32'h0);

        // Async reset mid-service
        svc_q.push_back(3'd3);
        pulse_ev(8'h08);
        pulse_ev(8'h08);
        wait_valid("rst_svc");
        chk("pre_rst_overrun", 32'(bus.overrun), 32'h08);
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", {23'b0, bus.req, bus.svc_valid}, 32'h0);
        chk("arst_id_done", {28'b0, bus.svc_id, bus.svc_done}, 32'h0);
        chk("arst_flags", {22'b0, bus.overrun, bus.to_err, bus.proto_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", {23'b0, bus.req, bus.svc_valid}, 32'h0);

        chk("svc_q_drained", 32'(svc_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
